// File: rtl/mod12_load_ctrl_if.sv
// Preset-request handshake between the two requesters and the mod-12 load controller.
// req is a level held with val stable until the controller answers with a one-cycle ack or err.
interface mod12_load_ctrl_if #(
   parameter int W = 4
);
   logic         req0;
   logic [W-1:0] val0;
   logic         ack0;
   logic         err0;
   logic         req1;
   logic [W-1:0] val1;
   logic         ack1;
   logic         err1;

   modport master (
      output req0, val0, req1, val1,
      input  ack0, err0, ack1, err1
   );

   modport slave (
      input  req0, val0, req1, val1,
      output ack0, err0, ack1, err1
   );
endinterface

// File: rtl/mod12_load_ctrl.sv
// Round-robin preset-load controller for a mod-12 counter with load readback
// verification and a saturating count of natural 11->0 wraps.
module mod12_load_ctrl #(
   parameter int MOD    = 12,
   parameter int W      = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   mod12_load_ctrl_if.slave  rq,
   input  logic [W-1:0]      cnt_in,
   output logic              ld,
   output logic [W-1:0]      din,
   output logic              busy,
   output logic              last_grant,
   input  logic              wrap_clr,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, RESP} state_t;

   localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

   state_t       state;
   logic         gnt;
   logic [W-1:0] prev_cnt;
   logic         ld_d;

   logic         pick;
   logic         any_req;
   logic [W-1:0] pick_val;
   logic         wrap;

   // On a tie the requester that was not granted last time wins.
   always_comb begin
      any_req  = rq.req0 | rq.req1;
      pick     = (rq.req0 && rq.req1) ? ~last_grant : rq.req1;
      pick_val = pick ? rq.val1 : rq.val0;
      wrap     = (prev_cnt == MAX_VAL) && (cnt_in == '0) && !ld_d;
   end

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ld         <= 1'b0;
         din        <= '0;
         busy       <= 1'b0;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         rq.ack0    <= 1'b0;
         rq.err0    <= 1'b0;
         rq.ack1    <= 1'b0;
         rq.err1    <= 1'b0;
      end else begin
         ld      <= 1'b0;
         rq.ack0 <= 1'b0;
         rq.err0 <= 1'b0;
         rq.ack1 <= 1'b0;
         rq.err1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt        <= pick;
                  last_grant <= pick;
                  busy       <= 1'b1;
                  if (pick_val <= MAX_VAL) begin
                     din   <= pick_val;
                     ld    <= 1'b1;
                     state <= LOAD;
                  end else begin
                     // Out-of-range values never touch the counter.
                     state <= RESP;
                     if (pick) rq.err1 <= 1'b1;
                     else      rq.err0 <= 1'b1;
                  end
               end
            end
            LOAD: begin
               state <= CHECK;
            end
            CHECK: begin
               state <= RESP;
               if (cnt_in == din) begin
                  if (gnt) rq.ack1 <= 1'b1;
                  else     rq.ack0 <= 1'b1;
               end else begin
                  if (gnt) rq.err1 <= 1'b1;
                  else     rq.err0 <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ld_d masks the 11->0 step that a load into 0 would otherwise look like.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_cnt <= '0;
         ld_d     <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         prev_cnt <= cnt_in;
         ld_d     <= ld;
         if (wrap_clr) begin
            wrap_cnt <= '0;
         end else if (wrap && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod12_load_ctrl.sv
// Bench for mod12_load_ctrl: table of single requests, tie/round-robin, readback
// failure, wrap counting and mid-transaction reset, with a modelled mod-12 counter.
module tb_mod12_load_ctrl;
  localparam int W      = 4;
  localparam int WRAP_W = 8;
  localparam int MOD    = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod12_load_ctrl_if #(.W(W)) rq ();

  logic [W-1:0]      cnt_in;
  logic              ld;
  logic [W-1:0]      din;
  logic              busy;
  logic              last_grant;
  logic              wrap_clr;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [1:0]        state_dbg;

  mod12_load_ctrl #(.MOD(MOD), .W(W), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rq         (rq),
    .cnt_in     (cnt_in),
    .ld         (ld),
    .din        (din),
    .busy       (busy),
    .last_grant (last_grant),
    .wrap_clr   (wrap_clr),
    .wrap_cnt   (wrap_cnt),
    .state_dbg  (state_dbg)
  );

  // counter model: preset override, then load, then free-run increment
  logic [W-1:0] cnt;
  logic         cnt_set;
  logic [W-1:0] cnt_set_val;
  logic         cnt_run;
  logic         cnt_follow;
  always @(posedge clk) begin
    if (cnt_set)                 cnt <= cnt_set_val;
    else if (cnt_follow && ld)   cnt <= din;
    else if (cnt_run)            cnt <= (cnt == W'(MOD - 1)) ? '0 : cnt + 1'b1;
  end
  assign cnt_in = cnt;

  // scoreboard: response code is {requester, is_err}
  logic [1:0]   exp_q[$];
  logic [W-1:0] ld_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc   = 0;
  bit           resp_seen;
  int           resp_cyc;
  logic         ld_prev;
  logic [W-1:0] exp_din;

  typedef struct {
    logic         id;
    logic [W-1:0] val;
    logic         err;
    int           lat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int n;
    logic [1:0] code;
    n = int'(rq.ack0) + int'(rq.err0) + int'(rq.ack1) + int'(rq.err1);
    if (ld) begin
      chk("ld_single_cycle", ld_prev, 0);
      chk("ld_expected", ld_q.size() > 0, 1);
      if (ld_q.size() > 0) chk("ld_din", din, ld_q.pop_front());
    end
    ld_prev = ld;
    if (n > 0) begin
      chk("resp_onehot", n, 1);
      code = {rq.ack1 | rq.err1, rq.err0 | rq.err1};
      chk("resp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("resp_code", code, exp_q.pop_front());
      resp_seen = 1'b1;
      resp_cyc  = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic preset_cnt(input logic [W-1:0] v);
    cnt_set     = 1'b1;
    cnt_set_val = v;
    tick();
    cnt_set     = 1'b0;
  endtask

  task automatic apply_reset();
    rq.req0 = 1'b0;
    rq.req1 = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    ld_q.delete();
    exp_din = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // driver: one request, wait for its response, check latency and busy
  task automatic do_req(input logic id, input logic [W-1:0] val, input logic exp_err,
                        input int exp_lat);
    int t0;
    exp_q.push_back({id, exp_err});
    if (int'(val) < MOD) begin
      ld_q.push_back(val);
      exp_din = val;
    end
    if (id) begin rq.req1 = 1'b1; rq.val1 = val; end
    else    begin rq.req0 = 1'b1; rq.val0 = val; end
    t0 = cyc;
    resp_seen = 1'b0;
    for (int i = 0; i < 10 && !resp_seen; i++) begin
      tick();
      chk("busy_during", busy, 1);
    end
    chk("resp_timeout", resp_seen, 1);
    chk("latency", resp_cyc - t0, exp_lat);
    rq.req0 = 1'b0;
    rq.req1 = 1'b0;
    chk("last_grant", last_grant, id);
    chk("din_hold", din, exp_din);
    tick();
    chk("busy_after", busy, 0);
    chk("state_idle", state_dbg, 0);
  endtask

  // both requesters at once: first grant must be requester 0, second follows after RESP
  task automatic do_both(input logic [W-1:0] v0, input logic [W-1:0] v1);
    int t0, got, c0, c1;
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    ld_q.push_back(v0);
    ld_q.push_back(v1);
    rq.req0 = 1'b1; rq.val0 = v0;
    rq.req1 = 1'b1; rq.val1 = v1;
    t0 = cyc; got = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      resp_seen = 1'b0;
      tick();
      if (resp_seen) begin
        if (got == 0) c0 = resp_cyc; else c1 = resp_cyc;
        if (rq.ack0 | rq.err0) rq.req0 = 1'b0;
        if (rq.ack1 | rq.err1) rq.req1 = 1'b0;
        got++;
      end
    end
    rq.req0 = 1'b0;
    rq.req1 = 1'b0;
    chk("both_resp_count", got, 2);
    chk("both_first_lat", c0 - t0, 3);
    chk("both_second_lat", c1 - t0, 7);
    chk("both_last_grant", last_grant, 1);
    exp_din = v1;
    chk("both_din", din, exp_din);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 4'd5,  1'b0, 3};
    tbl[1] = '{1'b1, 4'd12, 1'b1, 1};
    tbl[2] = '{1'b1, 4'd15, 1'b1, 1};
    tbl[3] = '{1'b0, 4'd0,  1'b0, 3};
    tbl[4] = '{1'b1, 4'd11, 1'b0, 3};
    tbl[5] = '{1'b0, 4'd13, 1'b1, 1};
    tbl[6] = '{1'b1, 4'd7,  1'b0, 3};

    rst = 1'b0;
    rq.req0 = 1'b0; rq.val0 = '0;
    rq.req1 = 1'b0; rq.val1 = '0;
    wrap_clr = 1'b0;
    cnt_set = 1'b1; cnt_set_val = '0;
    cnt_run = 1'b0; cnt_follow = 1'b1;
    ld_prev = 1'b0; exp_din = '0;
    resp_seen = 1'b0; resp_cyc = 0;

    tick();
    tick();
    chk("rst_ld", ld, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_resp", {rq.ack0, rq.err0, rq.ack1, rq.err1}, 0);
    rst = 1'b1;
    cnt_set = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_req(tbl[i].id, tbl[i].val, tbl[i].err, tbl[i].lat);

    // round-robin from a fresh reset: requester 0 wins the first tie
    apply_reset();
    do_both(4'd8, 4'd6);
    do_both(4'd3, 4'd10);

    // counter ignores the load: readback mismatch gives err
    cnt_follow = 1'b0;
    preset_cnt(4'd9);
    do_req(1'b0, 4'd11, 1'b1, 3);
    cnt_follow = 1'b1;

    // natural wraps: from 9, 30 increments pass 11->0 three times
    apply_reset();
    chk("wrap_start", wrap_cnt, 0);
    preset_cnt(4'd9);
    cnt_run = 1'b1;
    repeat (30) tick();
    cnt_run = 1'b0;
    tick();
    chk("wrap_three", wrap_cnt, 3);

    // load of 0 while count is 11 is not a wrap
    preset_cnt(4'd11);
    tick();
    do_req(1'b0, 4'd0, 1'b0, 3);
    tick();
    chk("wrap_load_ignored", wrap_cnt, 3);

    // clear beats a same-cycle wrap
    preset_cnt(4'd11);
    cnt_run = 1'b1;
    tick();
    cnt_run = 1'b0;
    wrap_clr = 1'b1;
    tick();
    wrap_clr = 1'b0;
    chk("wrap_clr_priority", wrap_cnt, 0);
    tick();
    chk("wrap_clr_hold", wrap_cnt, 0);

    // saturation at 255
    repeat (254) begin
      preset_cnt(4'd11);
      preset_cnt(4'd0);
    end
    tick();
    chk("wrap_254", wrap_cnt, 254);
    repeat (3) begin
      preset_cnt(4'd11);
      preset_cnt(4'd0);
    end
    tick();
    chk("wrap_saturate", wrap_cnt, 255);

    // reset during CHECK abandons the transaction
    apply_reset();
    rq.req0 = 1'b1;
    rq.val0 = 4'd4;
    ld_q.push_back(4'd4);
    tick();
    tick();
    chk("mid_state_check", state_dbg, 2);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_ld", ld, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last_grant", last_grant, 1);
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_resp", {rq.ack0, rq.err0, rq.ack1, rq.err1}, 0);
    rq.req0 = 1'b0;
    exp_din = '0;
    tick();
    rst = 1'b1;
    repeat (6) tick();
    do_req(1'b0, 4'd4, 1'b0, 3);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("ld_q_drained", ld_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
